swap_req_datapath: RTL

Request front-end and storage datapath for the memory-swap engine. Accepts swap requests as address pairs over a valid/ready handshake, holds the register-file storage and temp register, and issues a one-cycle `swap` pulse to the swap sequencer FSM. It then consumes the sequencer's `sel`/`we` phase outputs to move data A→T, B→A, T→B. It also provides a host read/write port to the register file and reports completion.

---
 rtl/swap_req_datapath.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/swap_req_datapath.sv
// Request front-end and register-file datapath for the memory-swap engine.
// Accepts one address pair at a time and performs A->T, B->A, T->B under the sequencer's phases.
module swap_req_datapath #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr_a,
    input  logic [AW-1:0] req_addr_b,
    output logic          swap,
    input  logic [1:0]    sel,
    input  logic          we,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          busy,
    output logic [15:0]   swap_cnt
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] PH_LOAD_TMP  = 2'd1;
    localparam logic [1:0] PH_COPY_B    = 2'd2;
    localparam logic [1:0] PH_STORE_TMP = 2'd3;

    logic          busy_q,     busy_d;
    logic          swap_q,     swap_d;
    logic          done_q,     done_d;
    logic          wr_err_q,   wr_err_d;
    logic [DW-1:0] tmp_q,      tmp_d;
    logic [AW-1:0] addr_a_q,   addr_a_d;
    logic [AW-1:0] addr_b_q,   addr_b_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;
    logic [15:0]   swap_cnt_q, swap_cnt_d;

    logic [DW-1:0] mem_q [DEPTH];

    // Single write port shared by the host (idle only) and the swap phases (busy only).
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic accept;
    logic phase_act;
    logic host_wr_ok;

    assign accept     = req_valid && !busy_q;
    assign phase_act  = busy_q && we;
    assign host_wr_ok = wr_en && !busy_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        busy_d     = busy_q;
        swap_d     = accept;
        done_d     = 1'b0;
        wr_err_d   = wr_en && busy_q;
        tmp_d      = tmp_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        swap_cnt_d = swap_cnt_q;
        rd_data_d  = mem_q[rd_addr];
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;

        if (accept) begin
            addr_a_d = req_addr_a;
            addr_b_d = req_addr_b;
            busy_d   = 1'b1;
        end

        if (host_wr_ok) begin
            mem_we = 1'b1;
        end

        if (phase_act) begin
            case (sel)
                PH_LOAD_TMP: begin
                    tmp_d = mem_q[addr_a_q];
                end
                PH_COPY_B: begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_a_q;
                    mem_wdata = mem_q[addr_b_q];
                end
                PH_STORE_TMP: begin
                    mem_we     = 1'b1;
                    mem_waddr  = addr_b_q;
                    mem_wdata  = tmp_q;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    swap_cnt_d = swap_cnt_q + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every update samples pre-edge values.
        if (reset) begin
            busy_q     <= 1'b0;
            swap_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            tmp_q      <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            rd_data_q  <= '0;
            swap_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            swap_q     <= swap_d;
            done_q     <= done_d;
            wr_err_q   <= wr_err_d;
            tmp_q      <= tmp_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            rd_data_q  <= rd_data_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: storage must clear on reset, so it is built from flops rather than a RAM macro.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign req_ready = ~busy_q;
    assign busy      = busy_q;
    assign swap      = swap_q;
    assign done      = done_q;
    assign wr_err    = wr_err_q;
    assign rd_data   = rd_data_q;
    assign swap_cnt  = swap_cnt_q;

endmodule
